count_table_drain: RTL and testbench
====================================

Name: count_table_drain

Overview:
- 8-entry x 32-bit counter table with two ports.
  - Writer side: a one-per-cycle increment port (read-modify-write, +1).
  - Reader side: a drain engine that sweeps every entry in address order and streams each (addr, value) pair out over a valid/ready handshake.
- Sits beside event-counting logic. Software or a debug collector drains a consistent snapshot of the counts without stalling increments.

Parameters:
- DEPTH, 8, number of table entries (power of two)
- WIDTH, 32, counter width in bits
- ADDR_W, 3, log2(DEPTH)

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- io_inc_valid  in  1  increment request this cycle
- io_inc_addr  in  ADDR_W  entry to increment
- io_start  in  1  request a full drain; sampled only in IDLE
- io_busy  out  1  high in any state other than IDLE
- io_out_valid  out  1  drain beat valid
- io_out_ready  in  1  consumer accepts beat
- io_out_addr  out  ADDR_W  entry index of current beat
- io_out_data  out  WIDTH  captured entry value
- io_done  out  1  one-cycle pulse after final beat accepted

Behaviour:
- Reset values:
  - FSM = IDLE, ptr = 0.
  - io_busy, io_out_valid, io_done = 0.
  - io_out_addr and io_out_data = 0.
  - Table contents are NOT reset.
- Increment:
  - If io_inc_valid, mem[io_inc_addr] <= mem[io_inc_addr] + 1 next edge.
  - Wraps modulo 2^WIDTH.
  - Accepted in every state, including during reset deassertion cycles after reset.
- FSM states:
  - IDLE: io_start=1 -> LOAD, ptr <= 0.
  - LOAD (1 cycle): out_data_r <= mem[ptr], where mem[ptr] is the combinational read of the current contents before any same-cycle increment. Also out_addr_r <= ptr. Next state SEND.
  - SEND: io_out_valid=1; data and addr held stable until handshake.
    - On io_out_valid & io_out_ready with ptr != DEPTH-1: ptr <= ptr+1, next state LOAD.
    - On handshake with ptr == DEPTH-1: next state IDLE, io_done=1 for the following cycle, ptr <= 0.
- Latency:
  - Start accepted at edge N.
  - First io_out_valid at cycle N+2.
  - Minimum 2 cycles per beat with io_out_ready held high.
  - Full drain = 2*DEPTH cycles.
- io_start while busy is ignored; it is not queued.
- io_out_valid never drops without a handshake, except on reset.
- Reset mid-drain:
  - Returns to IDLE with no done pulse.
  - A partial drain leaves the table untouched beyond beats already accepted.
- Simultaneous increment on the same address in the LOAD cycle: the captured value excludes that increment.

Optional Feature:
- Macro CLEAR_ON_READ_EN.
- Defined:
  - On each accepted beat, mem[ptr] <= mem[ptr] - out_data_r + (inc hit on ptr ? 1 : 0).
  - The subtraction is modulo 2^WIDTH, so increments landing between LOAD and handshake are preserved, not lost.
  - The increment path and clear path are merged into a single write for that address.
- Undefined: drain is read-only; the table is never written by the drain engine.

Decomposition:
- Shared package holds:
  - DEPTH/WIDTH/ADDR_W defaults.
  - FSM state enum {IDLE, LOAD, SEND}, 2-bit.
- One natural sub-module: count_table_mem, the storage array with one combinational read port (drain), one RMW increment port, and a merged write-arbitration mux (increment + optional clear).
- FSM and output registers stay in the top.

Test Plan:
- Prime and drain with backpressure:
  - Prime table to known values (with CLEAR_ON_READ_EN, drain once to zero first).
  - Increment addr 3 five times and addr 7 twice.
  - Start with io_out_ready=1 -> 8 beats, addr 0..7, data {0,0,0,5,0,0,0,2}, io_done pulse 16 cycles after start.
  - Repeat with io_out_ready toggling 1-in-3 -> identical beat sequence, data/addr stable while stalled.
- Increment during SEND:
  - Hold io_out_ready=0 on the beat for addr 3 (value 5) and increment addr 3 twice.
  - Beat shows 5.
  - With CLEAR_ON_READ_EN, a second drain reports addr 3 = 2; without it, it reports 7.
- Same-cycle collision at handshake:
  - Increment addr 3 in the same cycle addr 3's beat is accepted, with CLEAR_ON_READ_EN.
  - Next drain reports 1.
- Wrap-around: entry at 0xFFFFFFFF plus one increment -> drain reports 0x00000000.
- Start handling: io_start pulsed during SEND is ignored; io_busy stays 1 and exactly 8 beats are produced.
- Reset mid-drain:
  - Assert reset after the 3rd beat -> next cycle io_busy=0, io_out_valid=0, no io_done.
  - A fresh drain starts again at addr 0.

Source files
------------

// File: rtl/count_table_drain_pkg.sv
// Shared defaults and FSM encoding for the count_table_drain block.
// Clear-on-read drain is enabled by defining CLEAR_ON_READ_EN.
package count_table_drain_pkg;

  localparam int CTD_DEPTH  = 8;
  localparam int CTD_WIDTH  = 32;
  localparam int CTD_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/count_table_mem.sv
// Counter storage: one combinational drain read port, one +1 RMW port,
// and a merged per-entry write of increment and optional clear.
module count_table_mem
  import count_table_drain_pkg::*;
#(
  parameter int DEPTH  = CTD_DEPTH,
  parameter int WIDTH  = CTD_WIDTH,
  parameter int ADDR_W = CTD_ADDR_W
) (
  input  logic              clk,
  input  logic              i_inc_valid,
  input  logic [ADDR_W-1:0] i_inc_addr,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data,
  input  logic              i_clr_valid,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [WIDTH-1:0]  i_clr_val
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] w_nxt [DEPTH];
  logic [DEPTH-1:0] w_inc_hit;
  logic [DEPTH-1:0] w_clr_hit;

  assign o_rd_data = r_mem[i_rd_addr];

  // Subtracting the captured value keeps increments that arrived after LOAD.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_inc_hit[i] = i_inc_valid && (i_inc_addr == ADDR_W'(i));
      w_clr_hit[i] = i_clr_valid && (i_clr_addr == ADDR_W'(i));
      w_nxt[i]     = r_mem[i]
                   + {{(WIDTH-1){1'b0}}, w_inc_hit[i]}
                   - (w_clr_hit[i] ? i_clr_val : '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_inc_hit[i] || w_clr_hit[i]) begin
        r_mem[i] <= w_nxt[i];
      end
    end
  end

endmodule

// File: rtl/count_table_drain.sv
// Counter table with a handshaked drain engine (addr, value) per entry.
// Define CLEAR_ON_READ_EN to clear each entry as its beat is accepted.
module count_table_drain
  import count_table_drain_pkg::*;
#(
  parameter int DEPTH  = CTD_DEPTH,
  parameter int WIDTH  = CTD_WIDTH,
  parameter int ADDR_W = CTD_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_inc_valid,
  input  logic [ADDR_W-1:0] io_inc_addr,
  input  logic              io_start,
  output logic              io_busy,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [ADDR_W-1:0] io_out_addr,
  output logic [WIDTH-1:0]  io_out_data,
  output logic              io_done
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [ADDR_W-1:0] r_out_addr;
  logic [WIDTH-1:0]  r_out_data;
  logic [WIDTH-1:0]  w_rd_data;
  logic              r_done;
  logic              w_load;
  logic              w_fire;
  logic              w_last;
  logic              w_clr_valid;

  count_table_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk         (clk),
    .i_inc_valid (io_inc_valid),
    .i_inc_addr  (io_inc_addr),
    .i_rd_addr   (r_ptr),
    .o_rd_data   (w_rd_data),
    .i_clr_valid (w_clr_valid),
    .i_clr_addr  (r_out_addr),
    .i_clr_val   (r_out_data)
  );

`ifdef CLEAR_ON_READ_EN
  assign w_clr_valid = w_fire;
`else
  assign w_clr_valid = 1'b0;
`endif

  assign w_last = w_fire && (r_ptr == ADDR_W'(DEPTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_load      = 1'b0;
    w_fire      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (io_start) begin
          w_state_nxt = LOAD;
          w_ptr_nxt   = '0;
        end
      end
      LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = SEND;
      end
      SEND: begin
        if (io_out_ready) begin
          w_fire = 1'b1;
          if (r_ptr == ADDR_W'(DEPTH - 1)) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = '0;
          end else begin
            w_state_nxt = LOAD;
            w_ptr_nxt   = r_ptr + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_done  <= w_last;
      if (w_load) begin
        r_out_addr <= r_ptr;
        r_out_data <= w_rd_data;
      end
    end
  end

  assign io_busy      = (r_state != IDLE);
  assign io_out_valid = (r_state == SEND);
  assign io_out_addr  = r_out_addr;
  assign io_out_data  = r_out_data;
  assign io_done      = r_done;

endmodule

// File: tb/tb_count_table_drain.sv
// Directed bench for count_table_drain (build with or without CLEAR_ON_READ_EN).
module tb_count_table_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_inc_valid;
  logic [2:0]  io_inc_addr;
  logic        io_start;
  logic        io_busy;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [2:0]  io_out_addr;
  logic [31:0] io_out_data;
  logic        io_done;

  int n_vec = 0;
  int n_err = 0;

  count_table_drain dut (
    .clk          (clk),
    .reset        (reset),
    .io_inc_valid (io_inc_valid),
    .io_inc_addr  (io_inc_addr),
    .io_start     (io_start),
    .io_busy      (io_busy),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_addr  (io_out_addr),
    .io_out_data  (io_out_data),
    .io_done      (io_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] v [8]);
    for (int i = 0; i < 8; i++) dut.u_mem.r_mem[i] <= v[i];
    tick();
  endtask

  task automatic bump(input logic [2:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      io_inc_valid = 1'b1;
      io_inc_addr  = a;
      tick();
    end
    io_inc_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input logic [31:0] exp [8],
                       input int mode, input bit chk_lat,
                       input int stall_beat, input int coll_beat,
                       input bit poke, input int abort);
    int cyc;
    int beats;
    int scnt;
    bit held;
    bit r;
    logic [2:0]  la;
    logic [31:0] ld;
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
    cyc = 0; beats = 0; scnt = 0; held = 0;
    la = '0; ld = '0;
    while (beats < 8 && cyc < 400) begin
      if (abort >= 0 && beats == abort) break;
      r = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      io_inc_valid = 1'b0;
      io_start     = 1'b0;
      if (io_out_valid) begin
        if (beats == stall_beat && scnt < 2) begin
          r = 1'b0;
          io_inc_valid = 1'b1;
          io_inc_addr  = 3'(beats);
          scnt++;
        end
        if (beats == coll_beat && r) begin
          io_inc_valid = 1'b1;
          io_inc_addr  = 3'(beats);
        end
        if (poke && beats == 2) begin
          io_start = 1'b1;
          check({tag, "_busy"}, 32'(io_busy), 32'd1);
        end
        if (held) begin
          check($sformatf("%s_hold_a%0d", tag, beats), 32'(io_out_addr), 32'(la));
          check($sformatf("%s_hold_d%0d", tag, beats), io_out_data, ld);
        end
        if (r) begin
          check($sformatf("%s_a%0d", tag, beats), 32'(io_out_addr), 32'(beats));
          check($sformatf("%s_d%0d", tag, beats), io_out_data, exp[beats]);
          beats++;
        end
        held = !r;
        la = io_out_addr;
        ld = io_out_data;
      end else begin
        held = 1'b0;
      end
      io_out_ready = r;
      tick();
      cyc++;
    end
    io_out_ready = 1'b0;
    io_inc_valid = 1'b0;
    io_start     = 1'b0;
    if (abort >= 0) begin
      check({tag, "_abort_beats"}, 32'(beats), 32'(abort));
      return;
    end
    check({tag, "_beats"}, 32'(beats), 32'd8);
    if (chk_lat) check({tag, "_lat"}, 32'(cyc), 32'd16);
    check({tag, "_done"}, 32'(io_done), 32'd1);
    check({tag, "_idle"}, 32'(io_busy), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(io_done), 32'd0);
    if (poke) begin
      repeat (3) tick();
      check({tag, "_no_requeue"}, 32'(io_busy), 32'd0);
    end
  endtask

  logic [31:0] v [8];
  logic [31:0] e [8];
  logic [31:0] e2 [8];

  initial begin
    reset        = 1'b1;
    io_inc_valid = 1'b0;
    io_inc_addr  = '0;
    io_start     = 1'b0;
    io_out_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy",  32'(io_busy),      32'd0);
    check("rst_valid", 32'(io_out_valid), 32'd0);
    check("rst_done",  32'(io_done),      32'd0);
    check("rst_addr",  32'(io_out_addr),  32'd0);
    check("rst_data",  io_out_data,       32'd0);
    reset = 1'b0;
    tick();

    v = '{0, 0, 0, 0, 0, 0, 0, 0};
    preload(v);
    bump(3'd3, 5);
    bump(3'd7, 2);
    e = '{0, 0, 0, 5, 0, 0, 0, 2};
    drain("prime", e, 0, 1, -1, -1, 0, -1);

    preload(e);
    drain("bp", e, 1, 0, -1, -1, 0, -1);

    preload(e);
    drain("stall", e, 0, 0, 3, -1, 0, -1);
`ifdef CLEAR_ON_READ_EN
    e2 = '{0, 0, 0, 2, 0, 0, 0, 0};
`else
    e2 = '{0, 0, 0, 7, 0, 0, 0, 2};
`endif
    drain("post_stall", e2, 0, 1, -1, -1, 0, -1);

    preload(e);
    drain("coll", e, 0, 1, -1, 3, 0, -1);
`ifdef CLEAR_ON_READ_EN
    e2 = '{0, 0, 0, 1, 0, 0, 0, 0};
`else
    e2 = '{0, 0, 0, 6, 0, 0, 0, 2};
`endif
    drain("post_coll", e2, 0, 1, -1, -1, 0, -1);

    v = '{0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0};
    preload(v);
    bump(3'd5, 1);
    e2 = '{0, 0, 0, 0, 0, 0, 0, 0};
    drain("wrap", e2, 0, 1, -1, -1, 1, -1);

    v = '{10, 11, 12, 13, 14, 15, 16, 17};
    preload(v);
    drain("abort", v, 0, 0, -1, -1, 0, 3);
    reset = 1'b1;
    tick();
    check("abort_busy",  32'(io_busy),      32'd0);
    check("abort_valid", 32'(io_out_valid), 32'd0);
    check("abort_done",  32'(io_done),      32'd0);
    reset = 1'b0;
    tick();
    check("abort_done2", 32'(io_done), 32'd0);
`ifdef CLEAR_ON_READ_EN
    e2 = '{0, 0, 0, 13, 14, 15, 16, 17};
`else
    e2 = v;
`endif
    drain("fresh", e2, 0, 1, -1, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
